tty_router: RTL and testbench

Parametrised character router between the DekatronPC terminal port and any number of terminal channels (UART, Consul, future devices). It buffers printed characters in a TX FIFO and broadcasts each one to every enabled channel. It merges keyboard input from all enabled channels into an RX FIFO with round-robin arbitration and optional local echo. It replaces the compile-time choice between the Consul and UART paths with runtime channel enables, and runs in the 1 MHz CPU clock domain.

---
 rtl/tty_router.sv | 216 +++++++++++++++++++++
 tb/tb_tty_router.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tty_router.sv
// rtl/tty_router.sv - character router between the CPU terminal port and N terminal channels
//
// Ports:
//   Clk, Rst                  clock, synchronous active-high reset
//   tx_vld_i/tx_data_i/tx_rdy_o   CPU print stream into the TX FIFO
//   rx_vld_o/rx_data_o/rx_rdy_i   keyboard stream from the RX FIFO to the CPU
//   ch_tx_vld_o/ch_tx_rdy_i/ch_tx_data_o  per-channel broadcast of the TX FIFO head
//   ch_rx_vld_i/ch_rx_data_i  per-channel receive strobes (no backpressure)
//   tx_en_i/rx_en_i           runtime output/input channel enables
//   echo_i                    copy each received character into the TX FIFO
//   tx_level_o/rx_level_o     FIFO occupancy
//   rx_overflow_o             sticky per-channel drop flags

module tty_router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end
endmodule

module tty_router #(
  parameter int CHANNELS   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 8
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           tx_vld_i,
  input  logic [DATA_WIDTH-1:0]          tx_data_i,
  output logic                           tx_rdy_o,
  output logic                           rx_vld_o,
  output logic [DATA_WIDTH-1:0]          rx_data_o,
  input  logic                           rx_rdy_i,
  output logic [CHANNELS-1:0]            ch_tx_vld_o,
  input  logic [CHANNELS-1:0]            ch_tx_rdy_i,
  output logic [CHANNELS*DATA_WIDTH-1:0] ch_tx_data_o,
  input  logic [CHANNELS-1:0]            ch_rx_vld_i,
  input  logic [CHANNELS*DATA_WIDTH-1:0] ch_rx_data_i,
  input  logic [CHANNELS-1:0]            tx_en_i,
  input  logic [CHANNELS-1:0]            rx_en_i,
  input  logic                           echo_i,
  output logic [$clog2(TX_DEPTH):0]      tx_level_o,
  output logic [$clog2(RX_DEPTH):0]      rx_level_o,
  output logic [CHANNELS-1:0]            rx_overflow_o
);
  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                  tx_full, tx_empty, tx_push, tx_pop;
  logic [DATA_WIDTH-1:0] tx_head, tx_push_data;
  logic                  rx_full, rx_empty, rx_pop;
  logic [DATA_WIDTH-1:0] rx_head;

  logic [CHANNELS-1:0]   done_q;
  logic [CHANNELS-1:0]   accept;
  logic [CHANNELS-1:0]   served;

  logic [CHANNELS-1:0]   hold_full_q;
  logic [DATA_WIDTH-1:0] hold_data_q [CHANNELS];
  logic [CHANNELS-1:0]   overflow_q;
  logic [PTR_W-1:0]      ptr_q;

  logic                  can_grant;
  logic [CHANNELS-1:0]   grant;
  logic                  grant_any;
  logic [PTR_W-1:0]      grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  echo_push;

  // Round-robin search from ptr_q upward with wrap; first full holding register wins.
  always_comb begin
    logic [PTR_W:0]   idx_ext;
    logic [PTR_W-1:0] idx;
    grant      = '0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    idx_ext    = '0;
    idx        = '0;
    can_grant  = ~rx_full & (~echo_i | ~tx_full);
    for (int k = 0; k < CHANNELS; k++) begin
      idx_ext = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (idx_ext >= (PTR_W+1)'(CHANNELS)) idx_ext = idx_ext - (PTR_W+1)'(CHANNELS);
      idx = idx_ext[PTR_W-1:0];
      if (can_grant && !grant_any && hold_full_q[idx]) begin
        grant[idx] = 1'b1;
        grant_any  = 1'b1;
        grant_idx  = idx;
        grant_data = hold_data_q[idx];
      end
    end
  end

  assign echo_push    = grant_any & echo_i;
  assign tx_rdy_o     = ~tx_full & ~echo_push;
  assign tx_push      = echo_push | (tx_vld_i & tx_rdy_o);
  assign tx_push_data = echo_push ? grant_data : tx_data_i;

  // Broadcast: a channel is served once it has accepted, accepts now, or is disabled.
  assign ch_tx_vld_o  = {CHANNELS{~tx_empty}} & tx_en_i & ~done_q;
  assign ch_tx_data_o = {CHANNELS{tx_head}};
  assign accept       = ch_tx_vld_o & ch_tx_rdy_i;
  assign served       = done_q | ~tx_en_i | accept;
  assign tx_pop       = ~tx_empty & (&served);

  assign rx_vld_o      = ~rx_empty;
  assign rx_data_o     = rx_head;
  assign rx_pop        = rx_vld_o & rx_rdy_i;
  assign rx_overflow_o = overflow_q;

  tty_router_fifo #(.DEPTH(TX_DEPTH), .WIDTH(DATA_WIDTH)) u_tx_fifo (
    .clk       (Clk),
    .rst       (Rst),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .level     (tx_level_o),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  tty_router_fifo #(.DEPTH(RX_DEPTH), .WIDTH(DATA_WIDTH)) u_rx_fifo (
    .clk       (Clk),
    .rst       (Rst),
    .push      (grant_any),
    .push_data (grant_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .level     (rx_level_o),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  always_ff @(posedge Clk) begin
    if (Rst || tx_pop) done_q <= '0;
    else               done_q <= done_q | accept;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr_q <= '0;
    end else if (grant_any) begin
      ptr_q <= (grant_idx == PTR_W'(CHANNELS-1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // A register granted this cycle is free to take a new strobe without overflow.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hold_full_q <= '0;
      overflow_q  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch_rx_vld_i[i] && rx_en_i[i]) begin
          if (hold_full_q[i] && !grant[i]) overflow_q[i]  <= 1'b1;
          else                             hold_full_q[i] <= 1'b1;
        end else if (grant[i]) begin
          hold_full_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_rx_vld_i[i] && rx_en_i[i] && (!hold_full_q[i] || grant[i]))
        hold_data_q[i] <= ch_rx_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end
endmodule

// File: tb/tb_tty_router.sv
// tb/tb_tty_router.sv - self-checking bench for tty_router

module tb_tty_router;
  localparam int CH = 2;
  localparam int DW = 8;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          tx_vld_i;
  logic [DW-1:0] tx_data_i;
  logic          tx_rdy_o;
  logic          rx_vld_o;
  logic [DW-1:0] rx_data_o;
  logic          rx_rdy_i;
  logic [CH-1:0] ch_tx_vld_o;
  logic [CH-1:0] ch_tx_rdy_i;
  logic [CH*DW-1:0] ch_tx_data_o;
  logic [CH-1:0] ch_rx_vld_i;
  logic [CH*DW-1:0] ch_rx_data_i;
  logic [CH-1:0] tx_en_i;
  logic [CH-1:0] rx_en_i;
  logic          echo_i;
  logic [4:0]    tx_level_o;
  logic [3:0]    rx_level_o;
  logic [CH-1:0] rx_overflow_o;

  tty_router #(.CHANNELS(CH), .DATA_WIDTH(DW), .TX_DEPTH(16), .RX_DEPTH(8)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .tx_vld_i      (tx_vld_i),
    .tx_data_i     (tx_data_i),
    .tx_rdy_o      (tx_rdy_o),
    .rx_vld_o      (rx_vld_o),
    .rx_data_o     (rx_data_o),
    .rx_rdy_i      (rx_rdy_i),
    .ch_tx_vld_o   (ch_tx_vld_o),
    .ch_tx_rdy_i   (ch_tx_rdy_i),
    .ch_tx_data_o  (ch_tx_data_o),
    .ch_rx_vld_i   (ch_rx_vld_i),
    .ch_rx_data_i  (ch_rx_data_i),
    .tx_en_i       (tx_en_i),
    .rx_en_i       (rx_en_i),
    .echo_i        (echo_i),
    .tx_level_o    (tx_level_o),
    .rx_level_o    (rx_level_o),
    .rx_overflow_o (rx_overflow_o)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] exp_tx0[$];
  logic [DW-1:0] exp_tx1[$];
  logic [DW-1:0] exp_rx[$];

  typedef struct {
    logic [DW-1:0] data;
    logic [CH-1:0] en;
    logic [CH-1:0] exp_vld;
  } tx_vec_t;

  tx_vec_t tv[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_sb();
    exp_tx0.delete();
    exp_tx1.delete();
    exp_rx.delete();
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tx_vld_i = 1'b0; tx_data_i = '0; rx_rdy_i = 1'b0;
    ch_tx_rdy_i = '0; ch_rx_vld_i = '0; ch_rx_data_i = '0;
    tx_en_i = '0; rx_en_i = '0; echo_i = 1'b0;
    tick();
    tick();
    Rst = 1'b0;
    clear_sb();
  endtask

  task automatic rx_strobe(input logic [CH-1:0] mask, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    ch_rx_vld_i  = mask;
    ch_rx_data_i = {d1, d0};
    tick();
    ch_rx_vld_i  = '0;
  endtask

  task automatic sb_empty(input string tag);
    check({tag, "_tx0_left"}, exp_tx0.size(), 0);
    check({tag, "_tx1_left"}, exp_tx1.size(), 0);
    check({tag, "_rx_left"},  exp_rx.size(),  0);
  endtask

  // Scoreboard side: every accepted output beat is matched against the queue head.
  always @(negedge Clk) begin
    if (!Rst) begin
      if (ch_tx_vld_o[0] && ch_tx_rdy_i[0]) begin
        if (exp_tx0.size() == 0) begin
          checks++; failures++;
          $display("FAIL ch0_tx_unexpected actual=%0h expected=none", ch_tx_data_o[7:0]);
        end else check("ch0_tx_data", ch_tx_data_o[7:0], exp_tx0.pop_front());
      end
      if (ch_tx_vld_o[1] && ch_tx_rdy_i[1]) begin
        if (exp_tx1.size() == 0) begin
          checks++; failures++;
          $display("FAIL ch1_tx_unexpected actual=%0h expected=none", ch_tx_data_o[15:8]);
        end else check("ch1_tx_data", ch_tx_data_o[15:8], exp_tx1.pop_front());
      end
      if (rx_vld_o && rx_rdy_i) begin
        if (exp_rx.size() == 0) begin
          checks++; failures++;
          $display("FAIL rx_unexpected actual=%0h expected=none", rx_data_o);
        end else check("rx_data", rx_data_o, exp_rx.pop_front());
      end
    end
  end

  initial begin
    tv[0] = '{data: 8'h10, en: 2'b11, exp_vld: 2'b11};
    tv[1] = '{data: 8'h11, en: 2'b01, exp_vld: 2'b01};
    tv[2] = '{data: 8'h12, en: 2'b10, exp_vld: 2'b10};
    tv[3] = '{data: 8'h13, en: 2'b11, exp_vld: 2'b11};
    tv[4] = '{data: 8'h14, en: 2'b00, exp_vld: 2'b00};

    // Reset state
    do_reset();
    at_neg();
    check("rst_tx_level", tx_level_o, 0);
    check("rst_rx_level", rx_level_o, 0);
    check("rst_ch_tx_vld", ch_tx_vld_o, 0);
    check("rst_rx_vld", rx_vld_o, 0);
    check("rst_overflow", rx_overflow_o, 0);
    check("rst_tx_rdy", tx_rdy_o, 1);

    // Table-driven broadcast under varying enable masks and random readiness
    for (int v = 0; v < 5; v++) begin
      bit done_ok;
      tick();
      tx_en_i = tv[v].en; ch_tx_rdy_i = '0;
      tx_vld_i = 1'b1; tx_data_i = tv[v].data;
      if (tv[v].en[0]) exp_tx0.push_back(tv[v].data);
      if (tv[v].en[1]) exp_tx1.push_back(tv[v].data);
      at_neg();
      check("vec_tx_rdy", tx_rdy_o, 1);
      tick();
      tx_vld_i = 1'b0;
      at_neg();
      check("vec_first_vld", ch_tx_vld_o, tv[v].exp_vld);
      if (tv[v].exp_vld != 0) check("vec_lane_data", ch_tx_data_o, {tv[v].data, tv[v].data});
      done_ok = 1'b0;
      for (int c = 0; c < 50 && !done_ok; c++) begin
        tick();
        ch_tx_rdy_i = CH'($urandom_range(0, 3));
        at_neg();
        if (tx_level_o == 0 && ch_tx_vld_o == 0) done_ok = 1'b1;
      end
      check("vec_drain_timeout", done_ok, 1);
    end
    sb_empty("vec");

    // Stall channel 1 for three cycles
    do_reset();
    tx_en_i = 2'b11; ch_tx_rdy_i = 2'b01;
    tx_vld_i = 1'b1; tx_data_i = 8'h41;
    exp_tx0.push_back(8'h41); exp_tx1.push_back(8'h41);
    exp_tx0.push_back(8'h42); exp_tx1.push_back(8'h42);
    at_neg();
    check("stall_rdy", tx_rdy_o, 1);
    tick(); tx_data_i = 8'h42;
    at_neg();
    check("stall_c1_vld", ch_tx_vld_o, 2'b11);
    check("stall_c1_data", ch_tx_data_o, 16'h4141);
    check("stall_c1_level", tx_level_o, 1);
    tick(); tx_vld_i = 1'b0;
    at_neg();
    check("stall_c2_vld", ch_tx_vld_o, 2'b10);
    check("stall_c2_level", tx_level_o, 2);
    tick();
    at_neg();
    check("stall_c3_vld", ch_tx_vld_o, 2'b10);
    tick(); ch_tx_rdy_i = 2'b11;
    at_neg();
    check("stall_c4_vld", ch_tx_vld_o, 2'b10);
    check("stall_c4_level", tx_level_o, 2);
    tick();
    at_neg();
    check("stall_c5_vld", ch_tx_vld_o, 2'b11);
    check("stall_c5_data", ch_tx_data_o, 16'h4242);
    check("stall_c5_level", tx_level_o, 1);
    tick();
    at_neg();
    check("stall_c6_vld", ch_tx_vld_o, 2'b00);
    check("stall_c6_level", tx_level_o, 0);
    sb_empty("stall");

    // All outputs disabled: sixteen characters discarded
    do_reset();
    tx_en_i = 2'b00; ch_tx_rdy_i = 2'b11;
    for (int i = 0; i < 16; i++) begin
      tx_vld_i = 1'b1; tx_data_i = 8'hA0 + 8'(i);
      at_neg();
      check("disc_tx_rdy", tx_rdy_o, 1);
      check("disc_no_vld", ch_tx_vld_o, 0);
      tick();
    end
    tx_vld_i = 1'b0;
    tick();
    at_neg();
    check("disc_level", tx_level_o, 0);
    check("disc_no_vld_end", ch_tx_vld_o, 0);

    // Same-cycle strobes, latency and round-robin order
    do_reset();
    rx_en_i = 2'b11; rx_rdy_i = 1'b1;
    exp_rx.push_back(8'h31); exp_rx.push_back(8'h32);
    rx_strobe(2'b11, 8'h31, 8'h32);
    at_neg();
    check("rx_lat_n1", rx_vld_o, 0);
    tick();
    at_neg();
    check("rx_lat_n2_vld", rx_vld_o, 1);
    check("rx_lat_n2_data", rx_data_o, 8'h31);
    idle(4);
    exp_rx.push_back(8'h33); exp_rx.push_back(8'h34);
    rx_strobe(2'b11, 8'h33, 8'h34);
    idle(4);
    exp_rx.push_back(8'h35);
    rx_strobe(2'b10, 8'h00, 8'h35);
    idle(3);
    exp_rx.push_back(8'h36);
    rx_strobe(2'b01, 8'h36, 8'h00);
    idle(3);
    exp_rx.push_back(8'h38); exp_rx.push_back(8'h37);
    rx_strobe(2'b11, 8'h37, 8'h38);
    idle(5);
    check("rr_level", rx_level_o, 0);
    check("rr_no_overflow", rx_overflow_o, 0);
    sb_empty("rr");

    // Overflow with a full RX FIFO, then reset with both FIFOs populated
    do_reset();
    rx_en_i = 2'b11; rx_rdy_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_rx.push_back(8'h80 + 8'(k));
      rx_strobe(2'b01, 8'h80 + 8'(k), 8'h00);
    end
    tick();
    at_neg();
    check("ovf_fill_level", rx_level_o, 8);
    check("ovf_none_yet", rx_overflow_o, 0);
    tick();
    exp_rx.push_back(8'h55);
    rx_strobe(2'b01, 8'h55, 8'h00);
    tick();
    rx_strobe(2'b01, 8'h66, 8'h00);
    at_neg();
    check("ovf_set", rx_overflow_o, 2'b01);
    check("ovf_level", rx_level_o, 8);
    tick(); rx_rdy_i = 1'b1;
    idle(4);
    rx_rdy_i = 1'b0;
    at_neg();
    check("ovf_sticky", rx_overflow_o, 2'b01);
    check("ovf_level_after", rx_level_o, 5);
    tx_en_i = 2'b01; ch_tx_rdy_i = 2'b00;
    for (int k = 0; k < 8; k++) begin
      tx_vld_i = 1'b1; tx_data_i = 8'hC0 + 8'(k);
      tick();
    end
    at_neg();
    check("pre_rst_tx_level", tx_level_o, 8);
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0; tx_vld_i = 1'b0;
    clear_sb();
    at_neg();
    check("mid_rst_tx_level", tx_level_o, 0);
    check("mid_rst_rx_level", rx_level_o, 0);
    check("mid_rst_ch_vld", ch_tx_vld_o, 0);
    check("mid_rst_rx_vld", rx_vld_o, 0);
    check("mid_rst_overflow", rx_overflow_o, 0);

    // Echo latency into an empty TX FIFO
    do_reset();
    tx_en_i = 2'b01; ch_tx_rdy_i = 2'b01; rx_en_i = 2'b11; echo_i = 1'b1; rx_rdy_i = 1'b1;
    exp_rx.push_back(8'h46); exp_tx0.push_back(8'h46);
    rx_strobe(2'b01, 8'h46, 8'h00);
    at_neg();
    check("echo_n1_tx_rdy", tx_rdy_o, 0);
    check("echo_n1_ch_vld", ch_tx_vld_o, 0);
    tick();
    at_neg();
    check("echo_n2_ch_vld", ch_tx_vld_o, 2'b01);
    check("echo_n2_lane", ch_tx_data_o[7:0], 8'h46);
    check("echo_n2_rx_vld", rx_vld_o, 1);
    idle(3);
    sb_empty("echo1");

    // Echo ordering against a CPU holding tx_vld_i
    do_reset();
    tx_en_i = 2'b01; ch_tx_rdy_i = 2'b00; rx_en_i = 2'b11; echo_i = 1'b1; rx_rdy_i = 1'b0;
    tx_vld_i = 1'b1; tx_data_i = 8'h60;
    at_neg();
    check("echo2_c0_rdy", tx_rdy_o, 1);
    tick();
    tx_data_i = 8'h61;
    ch_rx_vld_i = 2'b10; ch_rx_data_i = {8'h45, 8'h00};
    at_neg();
    check("echo2_c1_rdy", tx_rdy_o, 1);
    tick();
    ch_rx_vld_i = '0; tx_data_i = 8'h62;
    at_neg();
    check("echo2_push_rdy", tx_rdy_o, 0);
    tick();
    at_neg();
    check("echo2_c3_rdy", tx_rdy_o, 1);
    check("echo2_rx_vld", rx_vld_o, 1);
    check("echo2_rx_data", rx_data_o, 8'h45);
    tick();
    tx_vld_i = 1'b0; ch_tx_rdy_i = 2'b01; rx_rdy_i = 1'b1;
    exp_tx0.push_back(8'h60); exp_tx0.push_back(8'h61);
    exp_tx0.push_back(8'h45); exp_tx0.push_back(8'h62);
    exp_rx.push_back(8'h45);
    idle(8);
    check("echo2_tx_level", tx_level_o, 0);
    sb_empty("echo2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
